// File: rtl/write_back_stage_if.sv
// Select encodings shared by the write-back stage and its port bundle.
// The package lives here so it is compiled ahead of every user.
package common;
  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_BRANCH = 2'd1
  } pc_sel_t;

  typedef enum logic [2:0] {
    RI_TYPE_LUI = 3'd0,
    LOAD        = 3'd1,
    JUMP        = 3'd2,
    ZICSR       = 3'd3,
    WB_MRET     = 3'd4,
    WB_NONE     = 3'd5
  } wb_sel_t;
endpackage

interface write_back_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  localparam int OFF_W = $clog2(XLEN / 8);

  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [XLEN-1:0]      in_pc_plus_4;
  logic [XLEN-1:0]      in_pc_branch;
  common::pc_sel_t      in_pc_sel;
  common::wb_sel_t      in_wb_sel;
  logic [4:0]           in_rd;
  logic [XLEN-1:0]      in_alu_result;
  logic [XLEN-1:0]      in_csr_data;
  logic [1:0]           in_ld_size;
  logic                 in_ld_unsigned;
  logic [OFF_W-1:0]     in_ld_offset;
  logic [XLEN-1:0]      mem_rdata;
  logic                 mem_rvalid;
  logic                 flush;
  logic                 rf_wr_en;
  logic [4:0]           rf_wr_addr;
  logic [XLEN-1:0]      rf_wr_data;
  logic [XLEN-1:0]      pc_next;
  logic                 pc_next_valid;
  logic                 retire;
  logic [CNT_W-1:0]     retire_count;

  modport master (
    output in_valid, in_pc, in_pc_plus_4, in_pc_branch, in_pc_sel, in_wb_sel,
           in_rd, in_alu_result, in_csr_data, in_ld_size, in_ld_unsigned,
           in_ld_offset, mem_rdata, mem_rvalid, flush,
    input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, pc_next, pc_next_valid,
           retire, retire_count
  );

  modport slave (
    input  in_valid, in_pc, in_pc_plus_4, in_pc_branch, in_pc_sel, in_wb_sel,
           in_rd, in_alu_result, in_csr_data, in_ld_size, in_ld_unsigned,
           in_ld_offset, mem_rdata, mem_rvalid, flush,
    output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, pc_next, pc_next_valid,
           retire, retire_count
  );
endinterface

// File: rtl/write_back_stage.sv
// Write-back stage: retires one instruction per cycle, stalling only on late load data.
//   state    | meaning
//   IDLE     | ready for a new instruction
//   WAIT_MEM | load accepted, fields latched, waiting for mem_rvalid or flush
module write_back_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  write_back_stage_if.slave bus
);
  import common::*;

  localparam int OFF_W = $clog2(XLEN / 8);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t state, state_nxt;
  logic   complete;
  logic   latch_en;

  logic [XLEN-1:0]  lat_pc_plus_4, lat_pc_branch, lat_alu, lat_csr;
  pc_sel_t          lat_pc_sel;
  wb_sel_t          lat_wb_sel;
  logic [4:0]       lat_rd;
  logic [1:0]       lat_ld_size;
  logic             lat_ld_unsigned;
  logic [OFF_W-1:0] lat_ld_offset;

  logic [XLEN-1:0]  cur_pc_plus_4, cur_pc_branch, cur_alu, cur_csr;
  pc_sel_t          cur_pc_sel;
  wb_sel_t          cur_wb_sel;
  logic [4:0]       cur_rd;
  logic [1:0]       cur_ld_size;
  logic             cur_ld_unsigned;
  logic [OFF_W-1:0] cur_ld_offset;

  logic [XLEN-1:0]  ld_raw, ld_val, wb_data, pc_val;
  logic             wb_wen;

  assign bus.in_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    latch_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_wb_sel == LOAD && !bus.mem_rvalid) begin
            latch_en  = 1'b1;
            state_nxt = WAIT_MEM;
          end else begin
            complete = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        // flush wins even when the load data shows up in the same cycle
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (bus.mem_rvalid) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (state == WAIT_MEM) begin
      cur_pc_plus_4   = lat_pc_plus_4;
      cur_pc_branch   = lat_pc_branch;
      cur_alu         = lat_alu;
      cur_csr         = lat_csr;
      cur_pc_sel      = lat_pc_sel;
      cur_wb_sel      = lat_wb_sel;
      cur_rd          = lat_rd;
      cur_ld_size     = lat_ld_size;
      cur_ld_unsigned = lat_ld_unsigned;
      cur_ld_offset   = lat_ld_offset;
    end else begin
      cur_pc_plus_4   = bus.in_pc_plus_4;
      cur_pc_branch   = bus.in_pc_branch;
      cur_alu         = bus.in_alu_result;
      cur_csr         = bus.in_csr_data;
      cur_pc_sel      = bus.in_pc_sel;
      cur_wb_sel      = bus.in_wb_sel;
      cur_rd          = bus.in_rd;
      cur_ld_size     = bus.in_ld_size;
      cur_ld_unsigned = bus.in_ld_unsigned;
      cur_ld_offset   = bus.in_ld_offset;
    end
  end

  assign ld_raw = bus.mem_rdata >> {cur_ld_offset, 3'b000};

  // A double load on a 32-bit datapath degrades to a word load.
  always_comb begin
    ld_val = '0;
    case (cur_ld_size)
      2'd0: ld_val = cur_ld_unsigned ? XLEN'(ld_raw[7:0])  : XLEN'($signed(ld_raw[7:0]));
      2'd1: ld_val = cur_ld_unsigned ? XLEN'(ld_raw[15:0]) : XLEN'($signed(ld_raw[15:0]));
      2'd2: ld_val = cur_ld_unsigned ? XLEN'(ld_raw[31:0]) : XLEN'($signed(ld_raw[31:0]));
      default: begin
        if (XLEN == 64) ld_val = ld_raw;
        else ld_val = cur_ld_unsigned ? XLEN'(ld_raw[31:0]) : XLEN'($signed(ld_raw[31:0]));
      end
    endcase
  end

  always_comb begin
    wb_data = '0;
    wb_wen  = 1'b0;
    case (cur_wb_sel)
      RI_TYPE_LUI: begin wb_data = cur_alu;       wb_wen = 1'b1; end
      LOAD:        begin wb_data = ld_val;        wb_wen = 1'b1; end
      JUMP:        begin wb_data = cur_pc_plus_4; wb_wen = 1'b1; end
      ZICSR:       begin wb_data = cur_csr;       wb_wen = 1'b1; end
      default:     begin wb_data = '0;            wb_wen = 1'b0; end
    endcase
  end

  always_comb begin
    pc_val = '0;
    case (cur_pc_sel)
      PC_BRANCH: pc_val = cur_alu[0] ? cur_pc_branch : cur_pc_plus_4;
      PC_NEXT:   pc_val = cur_pc_plus_4;
      default:   pc_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      bus.rf_wr_en      <= 1'b0;
      bus.rf_wr_addr    <= '0;
      bus.rf_wr_data    <= '0;
      bus.pc_next       <= '0;
      bus.pc_next_valid <= 1'b0;
      bus.retire        <= 1'b0;
      bus.retire_count  <= '0;
    end else begin
      state             <= state_nxt;
      bus.rf_wr_en      <= complete && wb_wen && (cur_rd != 5'd0);
      bus.pc_next_valid <= complete;
      bus.retire        <= complete;
      if (complete) begin
        bus.rf_wr_addr   <= cur_rd;
        bus.rf_wr_data   <= wb_data;
        bus.pc_next      <= pc_val;
        bus.retire_count <= bus.retire_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      lat_pc_plus_4   <= bus.in_pc_plus_4;
      lat_pc_branch   <= bus.in_pc_branch;
      lat_alu         <= bus.in_alu_result;
      lat_csr         <= bus.in_csr_data;
      lat_pc_sel      <= bus.in_pc_sel;
      lat_wb_sel      <= bus.in_wb_sel;
      lat_rd          <= bus.in_rd;
      lat_ld_size     <= bus.in_ld_size;
      lat_ld_unsigned <= bus.in_ld_unsigned;
      lat_ld_offset   <= bus.in_ld_offset;
    end
  end
endmodule

// File: tb/tb_write_back_stage.sv
// Drives a 32-bit (4-bit counter) and a 64-bit (8-bit counter) stage in lockstep
// and compares both against an arithmetic reference model.
module tb_write_back_stage;
  import common::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        t_valid, t_uns, t_rvalid, t_flush;
  logic [2:0]  t_wb, t_off;
  logic [1:0]  t_psel, t_size;
  logic [4:0]  t_rd;
  logic [63:0] t_pc, t_pc4, t_pcb, t_alu, t_csr, t_rdata;

  write_back_stage_if #(.XLEN(32), .CNT_W(4)) b32 ();
  write_back_stage_if #(.XLEN(64), .CNT_W(8)) b64 ();

  write_back_stage #(.XLEN(32), .CNT_W(4)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  write_back_stage #(.XLEN(64), .CNT_W(8)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  assign b32.in_valid       = t_valid;
  assign b32.in_pc          = t_pc[31:0];
  assign b32.in_pc_plus_4   = t_pc4[31:0];
  assign b32.in_pc_branch   = t_pcb[31:0];
  assign b32.in_pc_sel      = pc_sel_t'(t_psel);
  assign b32.in_wb_sel      = wb_sel_t'(t_wb);
  assign b32.in_rd          = t_rd;
  assign b32.in_alu_result  = t_alu[31:0];
  assign b32.in_csr_data    = t_csr[31:0];
  assign b32.in_ld_size     = t_size;
  assign b32.in_ld_unsigned = t_uns;
  assign b32.in_ld_offset   = t_off[1:0];
  assign b32.mem_rdata      = t_rdata[31:0];
  assign b32.mem_rvalid     = t_rvalid;
  assign b32.flush          = t_flush;

  assign b64.in_valid       = t_valid;
  assign b64.in_pc          = t_pc;
  assign b64.in_pc_plus_4   = t_pc4;
  assign b64.in_pc_branch   = t_pcb;
  assign b64.in_pc_sel      = pc_sel_t'(t_psel);
  assign b64.in_wb_sel      = wb_sel_t'(t_wb);
  assign b64.in_rd          = t_rd;
  assign b64.in_alu_result  = t_alu;
  assign b64.in_csr_data    = t_csr;
  assign b64.in_ld_size     = t_size;
  assign b64.in_ld_unsigned = t_uns;
  assign b64.in_ld_offset   = t_off;
  assign b64.mem_rdata      = t_rdata;
  assign b64.mem_rvalid     = t_rvalid;
  assign b64.flush          = t_flush;

  int checks = 0;
  int errors = 0;

  logic        e_en, e_pv;
  logic [4:0]  e_addr;
  logic [63:0] e32_data, e64_data, e32_pc, e64_pc;
  int          retired;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] xmask(input int xlen);
    return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] m_load(input int xlen, input logic [63:0] rdata,
                                         input int off, input int size, input bit uns);
    logic [63:0] raw, keep, val;
    int bits;
    raw  = (rdata & xmask(xlen)) >> (8 * off);
    bits = (size == 0) ? 8 : (size == 1) ? 16 : (size == 2) ? 32 : xlen;
    if (bits == 64) return raw;
    keep = (64'd1 << bits) - 64'd1;
    val  = raw & keep;
    if (!uns && raw[bits-1]) val = val | ~keep;
    return val & xmask(xlen);
  endfunction

  function automatic logic [63:0] m_wb(input int xlen, input int wb, input logic [63:0] alu,
                                       input logic [63:0] csr, input logic [63:0] pc4,
                                       input logic [63:0] rdata, input int size,
                                       input int off, input bit uns);
    case (wb)
      0:       return alu & xmask(xlen);
      1:       return m_load(xlen, rdata, (xlen == 32) ? off % 4 : off, size, uns);
      2:       return pc4 & xmask(xlen);
      3:       return csr & xmask(xlen);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] m_pc(input int xlen, input int psel, input logic [63:0] alu,
                                       input logic [63:0] pcb, input logic [63:0] pc4);
    if (psel == 1) return (alu[0] ? pcb : pc4) & xmask(xlen);
    if (psel == 0) return pc4 & xmask(xlen);
    return 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("ready32", b32.in_ready, 1);
    chk("ready64", b64.in_ready, 1);
    chk("wr_en32", b32.rf_wr_en, e_en);
    chk("wr_en64", b64.rf_wr_en, e_en);
    chk("wr_addr32", b32.rf_wr_addr, e_addr);
    chk("wr_addr64", b64.rf_wr_addr, e_addr);
    chk("wr_data32", b32.rf_wr_data, e32_data);
    chk("wr_data64", b64.rf_wr_data, e64_data);
    chk("pc_next32", b32.pc_next, e32_pc);
    chk("pc_next64", b64.pc_next, e64_pc);
    chk("pc_valid32", b32.pc_next_valid, e_pv);
    chk("pc_valid64", b64.pc_next_valid, e_pv);
    chk("retire32", b32.retire, e_pv);
    chk("retire64", b64.retire, e_pv);
    chk("count32", b32.retire_count, 64'(retired % 16));
    chk("count64", b64.retire_count, 64'(retired % 256));
  endtask

  task automatic clear_model();
    e_en = 0; e_pv = 0; e_addr = '0;
    e32_data = '0; e64_data = '0; e32_pc = '0; e64_pc = '0;
    retired = 0;
  endtask

  task automatic scramble();
    t_wb = 3'($urandom); t_psel = 2'($urandom); t_rd = 5'($urandom);
    t_alu = rnd64(); t_csr = rnd64(); t_pc4 = rnd64(); t_pcb = rnd64(); t_pc = rnd64();
    t_size = 2'($urandom); t_off = 3'($urandom); t_uns = 1'($urandom);
  endtask

  // fl_wait: 0 data returns, 1 flush alone, 2 flush together with data
  task automatic issue(input int wb, input int psel, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] csr,
                       input logic [63:0] pc4, input logic [63:0] pcb,
                       input logic [63:0] rdata, input int size, input int off,
                       input bit uns, input int lat, input int fl_wait, input bit fl_acc);
    bit is_load;
    int wl;
    is_load = (wb == 1);
    wl = is_load ? lat : 0;
    chk("ready_pre32", b32.in_ready, 1);
    chk("ready_pre64", b64.in_ready, 1);
    t_valid = 1; t_wb = wb[2:0]; t_psel = psel[1:0]; t_rd = rd;
    t_alu = alu; t_csr = csr; t_pc4 = pc4; t_pcb = pcb; t_pc = rnd64();
    t_size = size[1:0]; t_off = off[2:0]; t_uns = uns; t_flush = fl_acc;
    if (is_load) begin
      t_rvalid = (lat == 0);
      t_rdata  = (lat == 0) ? rdata : rnd64();
    end else begin
      t_rvalid = 1'($urandom);
      t_rdata  = rnd64();
    end
    @(posedge clk);
    for (int k = 0; k < wl; k++) begin
      @(negedge clk);
      chk("stall_ready32", b32.in_ready, 0);
      chk("stall_ready64", b64.in_ready, 0);
      chk("stall_wr_en32", b32.rf_wr_en, 0);
      chk("stall_retire64", b64.retire, 0);
      t_valid = 1'($urandom);
      scramble();
      t_flush = 0; t_rvalid = 0; t_rdata = rnd64();
      if (k == wl - 1) begin
        t_rvalid = (fl_wait != 1);
        t_rdata  = rdata;
        t_flush  = (fl_wait != 0);
      end
      @(posedge clk);
    end
    @(negedge clk);
    t_valid = 0; t_flush = 0; t_rvalid = 0;
    if (wl > 0 && fl_wait != 0) begin
      e_en = 0; e_pv = 0;
    end else begin
      e_en     = (wb <= 3) && (rd != 5'd0);
      e_pv     = 1;
      e_addr   = rd;
      e32_data = m_wb(32, wb, alu, csr, pc4, rdata, size, off, uns);
      e64_data = m_wb(64, wb, alu, csr, pc4, rdata, size, off, uns);
      e32_pc   = m_pc(32, psel, alu, pcb, pc4);
      e64_pc   = m_pc(64, psel, alu, pcb, pc4);
      retired++;
    end
    check_outs();
  endtask

  task automatic idle(input int n, input bit rv);
    for (int i = 0; i < n; i++) begin
      t_valid = 0; t_rvalid = rv; t_rdata = rnd64(); t_flush = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      e_en = 0; e_pv = 0;
      check_outs();
    end
    t_rvalid = 0; t_flush = 0;
  endtask

  initial begin
    rst_n = 0;
    t_valid = 0; t_rvalid = 0; t_flush = 0;
    scramble();
    t_rdata = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs();
    rst_n = 1;

    // LUI, then pulses must drop while values hold
    issue(0, 0, 5'd5, 64'h1234_5000, 0, 64'h104, 64'h200, 0, 0, 0, 0, 0, 0, 0);
    chk("lui_data32", b32.rf_wr_data, 64'h1234_5000);
    idle(1, 1'b0);

    // LB signed, offset 2, data three cycles late
    issue(1, 0, 5'd7, 64'h0, 0, 64'h108, 0, 64'h0080_0000, 0, 2, 0, 3, 0, 0);
    chk("lb_data32", b32.rf_wr_data, 64'hFFFF_FF80);

    // LHU, offset 6, same-cycle data
    issue(1, 0, 5'd8, 64'h0, 0, 64'h10C, 0, 64'hBEEF_0000_0000_0000, 1, 6, 1, 0, 0, 0);
    chk("lhu_data64", b64.rf_wr_data, 64'h0000_0000_0000_BEEF);

    // branch taken / not taken, JUMP to x0, illegal selects
    issue(0, 1, 5'd3, 64'h1, 0, 64'h44, 64'h80, 0, 0, 0, 0, 0, 0, 1);
    chk("br_taken64", b64.pc_next, 64'h80);
    issue(0, 1, 5'd3, 64'h10, 0, 64'h44, 64'h80, 0, 0, 0, 0, 0, 0, 0);
    issue(2, 0, 5'd0, 64'h5, 0, 64'h48, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(4, 2, 5'd9, 64'h77, 64'h99, 64'h4C, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(3, 0, 5'd10, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 64'h50, 0, 0, 0, 0, 0, 0, 0, 0);

    // flush with data in the same cycle, then flush alone
    issue(1, 0, 5'd11, 0, 0, 64'h54, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0, 2, 2, 0);
    issue(1, 0, 5'd12, 0, 0, 64'h58, 0, 64'h1234, 2, 0, 0, 1, 1, 0);
    idle(1, 1'b1);

    // reset while waiting for load data; stray data afterwards is ignored
    t_valid = 1; t_wb = 3'd1; t_rd = 5'd13; t_rvalid = 0; t_flush = 0;
    @(posedge clk);
    @(negedge clk);
    t_valid = 0;
    chk("wait_ready32", b32.in_ready, 0);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    clear_model();
    check_outs();
    idle(2, 1'b1);

    // sixteen retires wrap the 4-bit counter
    for (int i = 0; i < 16; i++)
      issue(0, 0, 5'($urandom_range(1, 31)), rnd64(), 0, rnd64(), 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap32", b32.retire_count, 0);

    for (int i = 0; i < 60; i++) begin
      int wb, fw;
      wb = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(0, 7));
      fw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      issue(wb, int'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
            rnd64(), rnd64(), rnd64(), rnd64(), rnd64(),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom),
            int'($urandom_range(0, 3)), fw, 1'($urandom));
      if ($urandom_range(0, 4) == 0) idle(1, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
